kem_sched: RTL and testbench

ML-KEM operation scheduler. Accepts one keygen, encap or decap request and runs that request's fixed sequence of start/done handshakes across the four KEM sub-modules: TRNG, hashG, sampleA and NTT. It drives the row and column indices for the matrix and vector steps, and a watchdog aborts any step that stalls. The block sits between the top-level KEM control port and the sub-module datapaths.

---
 rtl/kem_sched_pkg.sv | 46 ++++
 rtl/kem_sched_wdog.sv | 34 +++
 rtl/kem_sched.sv | 190 +++++++++++++++++++
 tb/tb_kem_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kem_sched_pkg.sv
// kem_sched_pkg: shared ML-KEM scheduler types and constants.
//   kem_mode_t   - one-hot request mode (keygen / encap / decap)
//   kem_module_t - one-hot sub-module select (TRNG / hashG / sampleA / NTT)
//   kem_phase_t  - scheduler state (IDLE, one state per sub-module, FIN)
package kem_sched_pkg;

   localparam int unsigned ML_KEM_K = 2;

   typedef logic [2:0] kem_mode_t;
   localparam kem_mode_t MODE_KEYGEN = 3'b001;
   localparam kem_mode_t MODE_ENCAP  = 3'b010;
   localparam kem_mode_t MODE_DECAP  = 3'b100;

   typedef logic [3:0] kem_module_t;
   localparam kem_module_t MOD_TRNG  = 4'b0001;
   localparam kem_module_t MOD_HASHG = 4'b0010;
   localparam kem_module_t MOD_SMPA  = 4'b0100;
   localparam kem_module_t MOD_NTT   = 4'b1000;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_TRNG,
      PH_HASHG,
      PH_SMPA,
      PH_NTT,
      PH_FIN
   } kem_phase_t;

   function automatic logic mode_is_onehot(input kem_mode_t m);
      return ($countones(m) == 1);
   endfunction

   // Sub-module driven by an active state; zero for IDLE and FIN.
   function automatic kem_module_t phase_module(input kem_phase_t p);
      kem_module_t m;
      case (p)
         PH_TRNG:  m = MOD_TRNG;
         PH_HASHG: m = MOD_HASHG;
         PH_SMPA:  m = MOD_SMPA;
         PH_NTT:   m = MOD_NTT;
         default:  m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/kem_sched_wdog.sv
// kem_sched_wdog: per-step stall watchdog.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - restart the count (held during a step's ISSUE cycle)
//   en_i       - count one WAIT cycle
//   expire_o   - this WAIT cycle brings the count to TIMEOUT
module kem_sched_wdog #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Flagged one cycle early so the scheduler's registered err lands on
   // issue cycle + TIMEOUT + 1, leaving the TIMEOUT-th wait cycle open for done.
   assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/kem_sched.sv
// kem_sched: ML-KEM operation scheduler.
// Runs one keygen/encap/decap request as a fixed series of start/done
// handshakes across TRNG, hashG, sampleA and NTT, driving matrix/vector
// indices and aborting any step that stalls past TIMEOUT wait cycles.
// Handshake: mod_start_o pulses one cycle per step (ISSUE); the step then
// waits (WAIT) for the matching mod_done_i bit. Other done bits, and any done
// seen in the ISSUE cycle, are ignored.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start_i      - request pulse, taken in IDLE or FIN
//   mode_i       - one-hot kem_mode_t, sampled with start_i
//   busy_o       - request in progress
//   done_o       - one-cycle completion pulse
//   err_o        - one-cycle pulse: bad mode or watchdog abort
//   mod_start_o  - one-hot kem_module_t start pulse
//   mod_done_i   - kem_module_t done pulses
//   row_o, col_o - step indices
module kem_sched
   import kem_sched_pkg::*;
#(
   parameter int unsigned K       = ML_KEM_K,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [2:0]           mode_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [3:0]           mod_start_o,
   input  logic [3:0]           mod_done_i,
   output logic [$clog2(K)-1:0] row_o,
   output logic [$clog2(K)-1:0] col_o
);

   localparam int unsigned IW = $clog2(K);
   localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

   kem_phase_t    state_q;
   logic          issue_q;
   kem_mode_t     mode_q;
   logic [IW-1:0] row_q;
   logic [IW-1:0] col_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   kem_module_t   mod_start_q;

   kem_module_t   active_mod;
   logic          wait_act;
   logic          step_done;
   logic          wd_expire;
   logic [IW-1:0] ntt_last_row;

   always_comb begin
      active_mod   = phase_module(state_q);
      wait_act     = (active_mod != '0) && !issue_q;
      step_done    = wait_act && ((mod_done_i & active_mod) != '0);
      // keygen transforms two vectors (s and e); encap/decap only one.
      ntt_last_row = (mode_q == MODE_KEYGEN) ? IW'(1) : '0;
   end

   kem_sched_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (issue_q),
      .en_i     (wait_act),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PH_IDLE;
         issue_q     <= 1'b0;
         mode_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mod_start_q <= '0;
      end else begin
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mod_start_q <= '0;
         case (state_q)
            // FIN behaves as IDLE for a new request so back-to-back works.
            PH_IDLE, PH_FIN: begin
               state_q <= PH_IDLE;
               issue_q <= 1'b0;
               row_q   <= '0;
               col_q   <= '0;
               if (start_i) begin
                  if (mode_is_onehot(mode_i)) begin
                     mode_q  <= mode_i;
                     busy_q  <= 1'b1;
                     issue_q <= 1'b1;
                     if (mode_i == MODE_DECAP) begin
                        state_q     <= PH_HASHG;
                        mod_start_q <= MOD_HASHG;
                     end else begin
                        state_q     <= PH_TRNG;
                        mod_start_q <= MOD_TRNG;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
               if (issue_q) begin
                  issue_q <= 1'b0;
               end else if (step_done) begin
                  // A valid done beats a same-cycle watchdog expiry.
                  issue_q <= 1'b1;
                  case (state_q)
                     PH_TRNG: begin
                        state_q     <= PH_HASHG;
                        mod_start_q <= MOD_HASHG;
                     end
                     PH_HASHG: begin
                        state_q     <= PH_SMPA;
                        mod_start_q <= MOD_SMPA;
                        row_q       <= '0;
                        col_q       <= '0;
                     end
                     PH_SMPA: begin
                        if (col_q == IDX_LAST) begin
                           col_q <= '0;
                           if (row_q == IDX_LAST) begin
                              row_q       <= '0;
                              state_q     <= PH_NTT;
                              mod_start_q <= MOD_NTT;
                           end else begin
                              row_q       <= row_q + IW'(1);
                              mod_start_q <= MOD_SMPA;
                           end
                        end else begin
                           col_q       <= col_q + IW'(1);
                           mod_start_q <= MOD_SMPA;
                        end
                     end
                     PH_NTT: begin
                        if (col_q == IDX_LAST) begin
                           col_q <= '0;
                           if (row_q == ntt_last_row) begin
                              row_q   <= '0;
                              state_q <= PH_FIN;
                              issue_q <= 1'b0;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                           end else begin
                              row_q       <= row_q + IW'(1);
                              mod_start_q <= MOD_NTT;
                           end
                        end else begin
                           col_q       <= col_q + IW'(1);
                           mod_start_q <= MOD_NTT;
                        end
                     end
                     default: begin
                        state_q <= PH_IDLE;
                        issue_q <= 1'b0;
                        busy_q  <= 1'b0;
                     end
                  endcase
               end else if (wd_expire) begin
                  state_q <= PH_IDLE;
                  issue_q <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign mod_start_o = mod_start_q;
   // Indices are only meaningful while busy; they read 0 otherwise.
   assign row_o       = row_q;
   assign col_o       = col_q;

endmodule

// File: tb/tb_kem_sched.sv
// tb_kem_sched: self-checking bench for kem_sched (K=2, TIMEOUT=16).
// Cycle convention: inputs change and outputs are sampled 1 time unit after
// each rising edge; an input set in cycle n is seen by the edge ending cycle n.
module tb_kem_sched;
   import kem_sched_pkg::*;

   localparam int K   = 2;
   localparam int IW  = $clog2(K);
   localparam int TMO = 16;
   localparam int W   = 4 + 2 * IW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic [2:0]    mode_i = '0;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [3:0]    mod_start_o;
   logic [3:0]    mod_done_i = '0;
   logic [IW-1:0] row_o;
   logic [IW-1:0] col_o;

   int vectors = 0;
   int miscompares = 0;

   // Expected start pulses of the current request: {module, row, col}.
   logic [W-1:0] exp_q[$];

   kem_sched #(
      .K       (K),
      .TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .mod_start_o (mod_start_o),
      .mod_done_i  (mod_done_i),
      .row_o       (row_o),
      .col_o       (col_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      start_i    = 1'b0;
      mod_done_i = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] pack(input logic [3:0] m, input int r, input int c);
      return {m, IW'(r), IW'(c)};
   endfunction

   // Step list straight from the operation table: TRNG (not decap), hashG,
   // K*K sampleA row-major, then K NTT elements per vector (2 vectors keygen).
   function automatic void build_model(input logic [2:0] mode);
      int nvec;
      exp_q.delete();
      if (mode != MODE_DECAP) exp_q.push_back(pack(MOD_TRNG, 0, 0));
      exp_q.push_back(pack(MOD_HASHG, 0, 0));
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            exp_q.push_back(pack(MOD_SMPA, r, c));
      nvec = (mode == MODE_KEYGEN) ? 2 : 1;
      for (int v = 0; v < nvec; v++)
         for (int c = 0; c < K; c++)
            exp_q.push_back(pack(MOD_NTT, v, c));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_start(input logic [2:0] mode);
      start_i = 1'b1;
      mode_i  = mode;
      step();
      start_i = 1'b0;
      mode_i  = 3'($urandom);
   endtask

   // Consume n expected steps: check the start pulse in the current cycle,
   // hold quiet for a random delay, return the done, land on the next cycle.
   task automatic drive_steps(input int n, input int dmin, input int dmax);
      logic [W-1:0] e;
      logic [W-1:0] got;
      int d;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL model_empty: step %0d has no expected entry", i);
            return;
         end
         e   = exp_q.pop_front();
         got = {mod_start_o, row_o, col_o};
         vectors++;
         if (got !== e || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL step_issue #%0d: got start=%b row=%0d col=%0d busy=%b, want start=%b row=%0d col=%0d busy=1",
                     i, mod_start_o, row_o, col_o, busy_o, e[W-1 -: 4], e[2*IW-1 -: IW], e[IW-1:0]);
         end
         d = $urandom_range(dmax, dmin);
         for (int j = 0; j < d; j++) begin
            step();
            vectors++;
            if (mod_start_o !== 4'b0 || busy_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
               miscompares++;
               $display("FAIL step_wait #%0d: got start=%b busy=%b done=%b err=%b, want 0000/1/0/0",
                        i, mod_start_o, busy_o, done_o, err_o);
            end
         end
         mod_done_i = e[W-1 -: 4];
         step();
         mod_done_i = '0;
      end
   endtask

   task automatic check_fin(input string name);
      vectors++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || mod_start_o !== 4'b0 || err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_fin: got done=%b busy=%b start=%b err=%b, want 1/0/0000/0",
                  name, done_o, busy_o, mod_start_o, err_o);
      end
   endtask

   task automatic check_idle(input string name);
      vectors++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || mod_start_o !== 4'b0 || err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: got done=%b busy=%b start=%b err=%b, want all 0",
                  name, done_o, busy_o, mod_start_o, err_o);
      end
   endtask

   task automatic run_seq(input logic [2:0] mode, input int dmin, input int dmax, input string name);
      build_model(mode);
      send_start(mode);
      drive_steps(exp_q.size(), dmin, dmax);
      check_fin(name);
      step();
      check_idle(name);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      vectors++;
      if ({busy_o, done_o, err_o, mod_start_o, row_o, col_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: got busy=%b done=%b err=%b start=%b row=%0d col=%0d, want all 0",
                  busy_o, done_o, err_o, mod_start_o, row_o, col_o);
      end
      rst_n = 1'b1;
      step();
      check_idle("reset_release");
   endtask

   task automatic test_keygen();
      run_seq(MODE_KEYGEN, 3, 3, "keygen");
   endtask

   task automatic test_decap();
      run_seq(MODE_DECAP, 1, 6, "decap");
   endtask

   task automatic test_encap();
      run_seq(MODE_ENCAP, 1, 6, "encap");
   endtask

   task automatic test_invalid_mode();
      logic [2:0] bad [5] = '{3'b110, 3'b000, 3'b111, 3'b011, 3'b101};
      for (int i = 0; i < 5; i++) begin
         send_start(bad[i]);
         vectors++;
         if (err_o !== 1'b1 || busy_o !== 1'b0 || mod_start_o !== 4'b0) begin
            miscompares++;
            $display("FAIL invalid_mode %b: got err=%b busy=%b start=%b, want 1/0/0000",
                     bad[i], err_o, busy_o, mod_start_o);
         end
         step();
         check_idle("invalid_mode_after");
      end
   endtask

   task automatic test_timeout();
      // Run 1: TRNG never answers.
      send_start(MODE_ENCAP);
      vectors++;
      if (mod_start_o !== MOD_TRNG) begin
         miscompares++;
         $display("FAIL timeout_issue: got start=%b, want %b", mod_start_o, MOD_TRNG);
      end
      for (int i = 1; i <= TMO; i++) begin
         step();
         vectors++;
         if (err_o !== 1'b0 || busy_o !== 1'b1 || mod_start_o !== 4'b0) begin
            miscompares++;
            $display("FAIL timeout_wait s+%0d: got err=%b busy=%b start=%b, want 0/1/0000",
                     i, err_o, busy_o, mod_start_o);
         end
      end
      step();
      vectors++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || mod_start_o !== 4'b0) begin
         miscompares++;
         $display("FAIL timeout_abort: got err=%b busy=%b start=%b, want 1/0/0000",
                  err_o, busy_o, mod_start_o);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         check_idle("timeout_after");
      end
      // Run 2: TRNG done on the last allowed cycle is accepted.
      send_start(MODE_ENCAP);
      for (int i = 1; i <= TMO; i++) step();
      mod_done_i = MOD_TRNG;
      step();
      mod_done_i = '0;
      vectors++;
      if (mod_start_o !== MOD_HASHG || busy_o !== 1'b1 || err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_late_done: got start=%b busy=%b err=%b, want %b/1/0",
                  mod_start_o, busy_o, err_o, MOD_HASHG);
      end
      // Let hashG stall as well: its own watchdog restarts at its issue.
      for (int i = 1; i <= TMO; i++) step();
      vectors++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_hashg_wait: got err=%b busy=%b, want 0/1", err_o, busy_o);
      end
      step();
      vectors++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_hashg_abort: got err=%b busy=%b, want 1/0", err_o, busy_o);
      end
      step();
   endtask

   task automatic test_ignore();
      logic [W-1:0] e;
      build_model(MODE_KEYGEN);
      send_start(MODE_KEYGEN);
      drive_steps(2, 1, 4);
      e = exp_q.pop_front();
      vectors++;
      if ({mod_start_o, row_o, col_o} !== e) begin
         miscompares++;
         $display("FAIL ignore_issue: got start=%b row=%0d col=%0d, want start=%b row=0 col=0",
                  mod_start_o, row_o, col_o, e[W-1 -: 4]);
      end
      // sampleA done in its ISSUE cycle: ignored.
      mod_done_i = MOD_SMPA;
      step();
      // NTT done plus a new request during the wait: ignored.
      mod_done_i = MOD_NTT;
      start_i    = 1'b1;
      mode_i     = MODE_ENCAP;
      step();
      mod_done_i = '0;
      start_i    = 1'b0;
      vectors++;
      if (mod_start_o !== 4'b0 || row_o !== IW'(0) || col_o !== IW'(0) || busy_o !== 1'b1 || err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_hold: got start=%b row=%0d col=%0d busy=%b err=%b, want 0000/0/0/1/0",
                  mod_start_o, row_o, col_o, busy_o, err_o);
      end
      mod_done_i = MOD_SMPA;
      step();
      mod_done_i = '0;
      e = exp_q.pop_front();
      vectors++;
      if ({mod_start_o, row_o, col_o} !== e) begin
         miscompares++;
         $display("FAIL ignore_advance: got start=%b row=%0d col=%0d, want start=%b row=%0d col=%0d",
                  mod_start_o, row_o, col_o, e[W-1 -: 4], e[2*IW-1 -: IW], e[IW-1:0]);
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      build_model(MODE_ENCAP);
      send_start(MODE_ENCAP);
      drive_steps(exp_q.size(), 1, 3);
      check_fin("b2b_first");
      build_model(MODE_DECAP);
      send_start(MODE_DECAP);
      drive_steps(exp_q.size(), 1, 3);
      check_fin("b2b_second");
      step();
      check_idle("b2b");
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] e;
      build_model(MODE_KEYGEN);
      send_start(MODE_KEYGEN);
      drive_steps(8, 1, 4);
      e = exp_q.pop_front();
      vectors++;
      if ({mod_start_o, row_o, col_o} !== e) begin
         miscompares++;
         $display("FAIL reset_mid_issue: got start=%b row=%0d col=%0d, want start=%b row=%0d col=%0d",
                  mod_start_o, row_o, col_o, e[W-1 -: 4], e[2*IW-1 -: IW], e[IW-1:0]);
      end
      step();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy_o, done_o, err_o, mod_start_o, row_o, col_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_clear: got busy=%b done=%b err=%b start=%b row=%0d col=%0d, want all 0",
                  busy_o, done_o, err_o, mod_start_o, row_o, col_o);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      check_idle("reset_mid_after");
      run_seq(MODE_ENCAP, 1, 5, "reset_mid_encap");
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_keygen();
      test_decap();
      test_encap();
      test_invalid_mode();
      test_timeout();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(2, 0))
            0:       run_seq(MODE_KEYGEN, 1, 8, "rand_keygen");
            1:       run_seq(MODE_ENCAP, 1, 8, "rand_encap");
            default: run_seq(MODE_DECAP, 1, 8, "rand_decap");
         endcase
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
